// File: rtl/sys_rst_ctrl_if.sv
// Control/status bundle of the reset sequencer: button and trap in, reset
// lines and supervisor status out.
interface sys_rst_ctrl_if;
  // All signals are plain levels with no valid/ready handshake. trap is acted
  // on only at a clock edge while the sequencer is in RUN. btn_rst may change
  // at any time. The outputs are registered and state_dbg mirrors the FSM
  // (0 HOLD, 1 PERIPH, 2 RUN, 3 LOCK).
  logic       btn_rst;
  logic       trap;
  logic       periph_rst;
  logic       cpu_rst;
  logic       running;
  logic       locked;
  logic [7:0] restart_cnt;
  logic [1:0] state_dbg;

  modport master (
    output btn_rst, trap,
    input  periph_rst, cpu_rst, running, locked, restart_cnt, state_dbg
  );

  modport slave (
    input  btn_rst, trap,
    output periph_rst, cpu_rst, running, locked, restart_cnt, state_dbg
  );
endinterface

// File: rtl/sys_rst_ctrl.sv
// Reset sequencer and trap supervisor: staged release (peripherals before CPU),
// bounded trap restarts with lock-out, and a debounced user restart button.
module sys_rst_ctrl #(
  parameter int HOLD_CYCLES  = 65535,
  parameter int STAGE_GAP    = 16,
  parameter int DEB_CYCLES   = 1000,
  parameter int MAX_RESTARTS = 3,
  parameter int TRAP_RESTART = 1
) (
  input logic           clk,
  input logic           reset,
  sys_rst_ctrl_if.slave bus
);

  localparam int MAX_HG = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int MAX_V  = (MAX_HG > DEB_CYCLES) ? MAX_HG : DEB_CYCLES;
  localparam int CW     = $clog2(MAX_V + 1);

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [7:0]    RC_MAX    = 8'(MAX_RESTARTS);
  localparam bit            RESTART_EN = (TRAP_RESTART != 0);

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_PERIPH = 2'd1,
    S_RUN    = 2'd2,
    S_LOCK   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    rc_q, rc_d;

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_prev_q;
  logic [CW-1:0] deb_cnt_q;
  logic          press_evt;

  logic          periph_rst_q, cpu_rst_q, running_q, locked_q;

  // Button: two-flop synchroniser, then the level must hold DEB_CYCLES samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
    end else begin
      sync1_q    <= bus.btn_rst;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      if (sync2_q != deb_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          deb_q     <= sync2_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + CW'(1);
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  assign press_evt = deb_q & ~deb_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HOLD;
      cnt_q   <= HOLD_LOAD;
      rc_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rc_q    <= rc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rc_d    = rc_q;
    if (press_evt) begin
      state_d = S_HOLD;
      cnt_d   = HOLD_LOAD;
      rc_d    = 8'd0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (cnt_q == '0) begin
            state_d = S_PERIPH;
            cnt_d   = GAP_LOAD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_PERIPH: begin
          if (cnt_q == '0) state_d = S_RUN;
          else             cnt_d   = cnt_q - CW'(1);
        end
        S_RUN: begin
          if (bus.trap) begin
            if (RESTART_EN && (rc_q < RC_MAX)) begin
              state_d = S_HOLD;
              cnt_d   = HOLD_LOAD;
              rc_d    = rc_q + 8'd1;
            end else begin
              state_d = S_LOCK;
            end
          end
        end
        S_LOCK: ;
        default: state_d = S_HOLD;
      endcase
    end
  end

  // Outputs are decoded from the next state so they land on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      periph_rst_q <= 1'b1;
      cpu_rst_q    <= 1'b1;
      running_q    <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      periph_rst_q <= (state_d == S_HOLD);
      cpu_rst_q    <= (state_d != S_RUN);
      running_q    <= (state_d == S_RUN);
      locked_q     <= (state_d == S_LOCK);
    end
  end

  assign bus.periph_rst  = periph_rst_q;
  assign bus.cpu_rst     = cpu_rst_q;
  assign bus.running     = running_q;
  assign bus.locked      = locked_q;
  assign bus.restart_cnt = rc_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_sys_rst_ctrl.sv
// Bench for sys_rst_ctrl: directed release/trap/lock/button scenarios followed
// by random traffic, all checked against a cycle-level reference model.
module tb_sys_rst_ctrl;

  localparam int HOLD = 16;
  localparam int GAP  = 4;
  localparam int DEB  = 8;
  localparam int MAXR = 2;
  localparam int W    = 14;

  logic clk;
  logic reset;
  sys_rst_ctrl_if ifc ();

  sys_rst_ctrl #(
    .HOLD_CYCLES (HOLD),
    .STAGE_GAP   (GAP),
    .DEB_CYCLES  (DEB),
    .MAX_RESTARTS(MAXR),
    .TRAP_RESTART(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // t counts edges since the last entry to HOLD (saturating once running);
  // the release stages and RUN follow directly from comparing t to HOLD/GAP.
  int   m_t = 0;
  int   m_rc = 0;
  bit   m_lock = 0;
  bit   m_s1 = 0, m_s2 = 0, m_deb = 0, m_pend = 0, m_press = 0;
  int   m_dcnt = 0;
  logic [W-1:0] m_vec;

  function automatic logic [W-1:0] model_out(int t, int rc, bit lk);
    logic p, c, r, l;
    logic [1:0] st;
    if (lk) begin
      p = 0; c = 1; r = 0; l = 1; st = 2'd3;
    end else begin
      p = (t < HOLD);
      c = (t < HOLD + GAP);
      r = !c;
      l = 0;
      st = (t < HOLD) ? 2'd0 : (t < HOLD + GAP) ? 2'd1 : 2'd2;
    end
    return {p, c, r, l, 8'(rc), st};
  endfunction

  always @(posedge clk) begin
    m_press = m_pend;
    m_pend  = 0;
    if (reset) begin
      m_t = 0; m_rc = 0; m_lock = 0;
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_dcnt = 0;
    end else begin
      if (m_s2 != m_deb) begin
        m_dcnt++;
        if (m_dcnt == DEB) begin
          if (m_s2) m_pend = 1;
          m_deb  = m_s2;
          m_dcnt = 0;
        end
      end else begin
        m_dcnt = 0;
      end
      m_s2 = m_s1;
      m_s1 = ifc.btn_rst;
      if (m_press) begin
        m_t = 0; m_rc = 0; m_lock = 0;
      end else if (!m_lock && m_t >= HOLD + GAP && ifc.trap) begin
        if (m_rc < MAXR) begin
          m_rc++;
          m_t = 0;
        end else begin
          m_lock = 1;
        end
      end else if (!m_lock && m_t < HOLD + GAP) begin
        m_t++;
      end
    end
    m_vec = model_out(m_t, m_rc, m_lock);
    exp_q.push_back(m_vec);
  end

  // ---------------- monitor ----------------
  logic [W-1:0] act_vec, exp_vec;
  always @(negedge clk) begin
    act_vec = {ifc.periph_rst, ifc.cpu_rst, ifc.running, ifc.locked,
               ifc.restart_cnt, ifc.state_dbg};
    if (exp_q.size() == 0) begin
      tests++;
      errors++;
      $display("FAIL scoreboard_empty at %0t: got %h with no expectation", $time, act_vec);
    end else begin
      exp_vec = exp_q.pop_front();
      tests++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL outputs at %0t: got %b required %b (prst,crst,run,lock,rc[8],st[2])",
                 $time, act_vec, exp_vec);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_trap();
    ifc.trap = 1'b1;
    tick(1);
    ifc.trap = 1'b0;
  endtask

  task automatic wait_running();
    int n = 0;
    while (!ifc.running && n < 200) begin
      tick(1);
      n++;
    end
    check("wait_running", int'(ifc.running), 1);
  endtask

  // Called right after reset is driven low (or a restart began): counts edges
  // until each reset line drops.
  task automatic measure_release(input string tag);
    int pk = -1;
    int ck = -1;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (pk < 0 && !ifc.periph_rst) pk = k;
      if (ck < 0 && !ifc.cpu_rst && ifc.running) ck = k;
    end
    check({tag, "_periph_edge"}, pk, HOLD);
    check({tag, "_cpu_edge"}, ck, HOLD + GAP);
  endtask

  // ---------------- stimulus ----------------
  int btn_left;
  int lk_edge;

  initial begin
    reset       = 1'b1;
    ifc.btn_rst = 1'b0;
    ifc.trap    = 1'b0;
    tick(3);
    check("reset_periph", int'(ifc.periph_rst), 1);
    check("reset_cpu", int'(ifc.cpu_rst), 1);
    check("reset_rc", int'(ifc.restart_cnt), 0);
    reset = 1'b0;
    measure_release("powerup");

    // trap restart repeats the full sequence
    pulse_trap();
    check("trap1_rc", int'(ifc.restart_cnt), 1);
    check("trap1_periph", int'(ifc.periph_rst), 1);
    measure_release("restart1");
    pulse_trap();
    wait_running();
    pulse_trap();
    check("lock_flag", int'(ifc.locked), 1);
    check("lock_rc", int'(ifc.restart_cnt), MAXR);
    pulse_trap();
    tick(3);
    check("lock_holds", int'(ifc.locked), 1);

    // short bounces produce no event
    for (int i = 0; i < 3; i++) begin
      ifc.btn_rst = 1'b1;
      tick(5);
      ifc.btn_rst = 1'b0;
      tick(12);
    end
    check("bounce_locked", int'(ifc.locked), 1);

    // 12-cycle press leaves LOCK 11 edges after it starts
    lk_edge = -1;
    ifc.btn_rst = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (k == 12) ifc.btn_rst = 1'b0;
      if (lk_edge < 0 && !ifc.locked) lk_edge = k;
    end
    check("press_edge", lk_edge, 11);
    check("press_rc", int'(ifc.restart_cnt), 0);

    // reset asserted during PERIPH restarts the sequence
    begin
      int n = 0;
      while (!(ifc.cpu_rst && !ifc.periph_rst) && n < 200) begin
        tick(1);
        n++;
      end
      check("reach_periph", int'(ifc.state_dbg), 1);
    end
    reset = 1'b1;
    tick(1);
    check("midreset_periph", int'(ifc.periph_rst), 1);
    reset = 1'b0;
    measure_release("midreset");

    // press event and trap on the same edge: press wins
    pulse_trap();
    wait_running();
    ifc.btn_rst = 1'b1;
    tick(10);
    ifc.trap = 1'b1;
    tick(1);
    ifc.trap = 1'b0;
    check("simul_rc", int'(ifc.restart_cnt), 0);
    check("simul_state", int'(ifc.state_dbg), 0);
    tick(1);
    ifc.btn_rst = 1'b0;
    tick(30);

    // random traffic
    btn_left = 0;
    for (int c = 0; c < 4000; c++) begin
      reset    = ($urandom_range(0, 1499) == 0);
      ifc.trap = ($urandom_range(0, 24) == 0);
      if (btn_left > 0) begin
        btn_left--;
        ifc.btn_rst = (btn_left != 0);
      end else if ($urandom_range(0, 149) == 0) begin
        btn_left    = $urandom_range(2, 16);
        ifc.btn_rst = 1'b1;
      end
      tick(1);
    end
    reset       = 1'b0;
    ifc.trap    = 1'b0;
    ifc.btn_rst = 1'b0;
    tick(5);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/sys_rst_ctrl.md
# sys_rst_ctrl

Reset sequencer and trap supervisor for the SoC top level. It replaces the bare power-on counter. It holds the system in reset for a programmable interval, then releases peripherals (UART) before the CPU. While the system runs it watches `trap` and restarts it a bounded number of times. A debounced user button forces a full restart.

## Interface
Parameters:
- `HOLD_CYCLES`, 65535: cycles both resets stay asserted on entry to HOLD (≥1).
- `STAGE_GAP`, 16: cycles between peripheral release and CPU release (≥1).
- `DEB_CYCLES`, 1000: cycles the button must stay stable before its level is accepted (≥1).
- `MAX_RESTARTS`, 3: trap-triggered restarts allowed before lock (0–255).
- `TRAP_RESTART`, 1: 1 means restart on trap; 0 means lock on the first trap.

Ports:
- `clk` in, 1: system clock.
- `reset` in, 1: one clock; reset is synchronous and active-high.
- `btn_rst` in, 1: raw user button, asynchronous, active-high.
- `trap` in, 1: CPU trap, synchronous to `clk`.
- `periph_rst` out, 1: peripheral reset, active-high, registered.
- `cpu_rst` out, 1: CPU reset, active-high, registered.
- `running` out, 1: high in RUN.
- `locked` out, 1: high in LOCK.
- `restart_cnt` out, 8: trap-triggered restarts since the last reset or button restart.

## Operation
- Reset values: `periph_rst`=1, `cpu_rst`=1, `running`=0, `locked`=0, `restart_cnt`=0. State is HOLD and the counter is loaded with HOLD_CYCLES-1. The debouncer state is set to 0.
- Button path:
  - 2-flop synchroniser, then a stability counter.
  - The debounced level takes the synchronised value after DEB_CYCLES consecutive equal samples.
  - A 0→1 transition of the debounced level is a press event.
- States:
  - HOLD: both resets = 1, counter decrements. When counter = 0, go to PERIPH and load STAGE_GAP-1.
  - PERIPH: `periph_rst`=0, `cpu_rst`=1, counter decrements. When counter = 0, go to RUN.
  - RUN: both resets = 0, `running`=1. `trap` is sampled only in this state.
  - Trap in RUN:
    - If TRAP_RESTART=1 and `restart_cnt` < MAX_RESTARTS: increment `restart_cnt`, go to HOLD, reload HOLD_CYCLES-1.
    - Otherwise go to LOCK.
  - LOCK: `cpu_rst`=1, `periph_rst`=0 (UART stays alive for debug), `locked`=1. Exits only on `reset` or a press event.
- Press event, from any state: clear `restart_cnt`, go to HOLD, reload the counter.
- Priority: `reset` > press event > trap > counter expiry.
- `restart_cnt` never exceeds MAX_RESTARTS; it never wraps.
- Counters are sized to fit max(HOLD_CYCLES, STAGE_GAP, DEB_CYCLES).

## Timing
- All outputs are registered and change only on rising `clk` edges.
- Release sequence, with edge 1 being the first edge at which `reset` is sampled low:
  - `periph_rst` goes low after edge HOLD_CYCLES.
  - `cpu_rst` goes low, and `running` goes high, after edge HOLD_CYCLES+STAGE_GAP.
- Trap response: if `trap` is high at edge N while in RUN, then after edge N the following hold:
  - both resets are high, `running`=0, and `restart_cnt` has its new value (restart case);
  - or `cpu_rst`=1, `periph_rst`=0, `locked`=1 (lock case).
- A one-cycle `trap` pulse is sufficient. `trap` held high outside RUN is ignored.
- Press latency: the debounced level changes DEB_CYCLES+2 edges after `btn_rst` settles. Outputs enter the HOLD values on the edge after that change.
- `reset` asserted mid-sequence: all outputs and state return to reset values on the next edge, regardless of state.
- A button bounce shorter than DEB_CYCLES produces no event. The stability counter restarts on every change.

## Test plan
- Power-up, HOLD_CYCLES=16, STAGE_GAP=4: `reset` high for 3 cycles, then low. Required: `periph_rst` low after edge 16; `cpu_rst` low and `running` high after edge 20.
- Trap restart, MAX_RESTARTS=2: 1-cycle `trap` pulse in RUN. Required: next cycle both resets high, `restart_cnt`=1, `running`=0; full release sequence repeats (16/20 cycles).
- Lock: third trap with MAX_RESTARTS=2. Required: `locked`=1, `cpu_rst`=1, `periph_rst`=0, `restart_cnt` stays 2; further traps are ignored.
- Debounce, DEB_CYCLES=8:
  - 5-cycle button pulses: no change to state or outputs.
  - 12-cycle press: HOLD entered 11 edges after the press start; `restart_cnt`=0; LOCK exited.
- Mid-sequence reset: assert `reset` during PERIPH. Required: outputs return to reset values on the next edge, and the full 16/20 sequence restarts.
- Simultaneous press event and `trap` in RUN. Required: press wins; `restart_cnt`=0; state HOLD.
